// File: rtl/srl_fifo_multich_if.sv
// Bundle of per-channel FIFO handshake, data and status signals shared by producer/consumer and FIFO.
// The FIFO side uses the slave modport; the PE side driving writes/reads uses master.
interface srl_fifo_multich_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CH      = 2,
  parameter int LEVEL_WIDTH = 3
);
  logic [NUM_CH-1:0]             clr;
  logic [NUM_CH-1:0]             if_write;
  logic [NUM_CH*DATA_WIDTH-1:0]  if_din;
  logic [NUM_CH-1:0]             if_full_n;
  logic [NUM_CH-1:0]             if_read;
  logic [NUM_CH*DATA_WIDTH-1:0]  if_dout;
  logic [NUM_CH-1:0]             if_empty_n;
  logic [NUM_CH-1:0]             almost_full;
  logic [NUM_CH*LEVEL_WIDTH-1:0] level;

  modport master (
    output clr, if_write, if_din, if_read,
    input  if_full_n, if_dout, if_empty_n, almost_full, level
  );

  modport slave (
    input  clr, if_write, if_din, if_read,
    output if_full_n, if_dout, if_empty_n, almost_full, level
  );
endinterface

// File: rtl/srl_fifo_multich.sv
// NUM_CH independent shift-register FIFOs with per-channel clear and optional registered FWFT head.
// Write-to-valid latency 1 cycle; writes are refused while full_n=0, reads ignored while empty_n=0.
module srl_fifo_multich #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int NUM_CH     = 2,
  parameter int OUT_REG    = 1,
  parameter int AF_THRESH  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  srl_fifo_multich_if.slave bus
);

  localparam int ADDR_WIDTH  = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
  localparam int LEVEL_WIDTH = $clog2(DEPTH + 2);

  logic [NUM_CH-1:0]             full_n_w;
  logic [NUM_CH-1:0]             empty_n_w;
  logic [NUM_CH-1:0]             af_w;
  logic [NUM_CH*DATA_WIDTH-1:0]  dout_w;
  logic [NUM_CH*LEVEL_WIDTH-1:0] level_w;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DATA_WIDTH-1:0]  srl_q [DEPTH];
    logic [DATA_WIDTH-1:0]  out_q;
    logic [LEVEL_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0]  din, head;
    logic [LEVEL_WIDTH-1:0] lvl;
    logic srl_empty, srl_full;
    logic wr_acc, rd_acc, out_free, load_srl, load_byp, push, pop;

    assign din       = bus.if_din[k*DATA_WIDTH +: DATA_WIDTH];
    assign head      = srl_q[addr_q];
    assign srl_empty = (cnt_q == '0);
    assign srl_full  = (cnt_q == LEVEL_WIDTH'(DEPTH));

    always_comb begin
      wr_acc    = bus.if_write[k] & ~srl_full & ~bus.clr[k];
      rd_acc    = 1'b0;
      out_free  = 1'b0;
      load_srl  = 1'b0;
      load_byp  = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      out_vld_d = out_vld_q;
      if (OUT_REG != 0) begin
        // The head register refills from the SRL first; an empty SRL lets the write bypass straight in.
        rd_acc   = bus.if_read[k] & out_vld_q & ~bus.clr[k];
        out_free = ~out_vld_q | rd_acc;
        load_srl = out_free & ~srl_empty;
        load_byp = out_free & srl_empty & wr_acc;
        pop      = load_srl;
        push     = wr_acc & ~load_byp;
        if (out_free) out_vld_d = load_srl | load_byp;
      end else begin
        rd_acc    = bus.if_read[k] & ~srl_empty & ~bus.clr[k];
        pop       = rd_acc;
        push      = wr_acc;
        out_vld_d = 1'b0;
      end

      cnt_d  = cnt_q;
      addr_d = addr_q;
      if (push && !pop) begin
        cnt_d = cnt_q + LEVEL_WIDTH'(1);
        if (!srl_empty) addr_d = addr_q + ADDR_WIDTH'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - LEVEL_WIDTH'(1);
        if (cnt_q != LEVEL_WIDTH'(1)) addr_d = addr_q - ADDR_WIDTH'(1);
      end

      if (bus.clr[k]) begin
        cnt_d     = '0;
        addr_d    = '0;
        out_vld_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q     <= '0;
        addr_q    <= '0;
        out_vld_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        addr_q    <= addr_d;
        out_vld_q <= out_vld_d;
      end
    end

    // Data storage is left unreset so it maps onto shift-register primitives.
    always_ff @(posedge clk) begin
      if (push) begin
        for (int i = DEPTH - 1; i > 0; i--) srl_q[i] <= srl_q[i-1];
        srl_q[0] <= din;
      end
      if (load_srl)      out_q <= head;
      else if (load_byp) out_q <= din;
    end

    assign lvl                                    = cnt_q + LEVEL_WIDTH'(out_vld_q);
    assign level_w[k*LEVEL_WIDTH +: LEVEL_WIDTH]  = lvl;
    assign af_w[k]                                = (lvl >= LEVEL_WIDTH'(AF_THRESH));
    assign full_n_w[k]                            = ~srl_full;
    assign empty_n_w[k]                           = (OUT_REG != 0) ? out_vld_q : ~srl_empty;
    assign dout_w[k*DATA_WIDTH +: DATA_WIDTH]     = (OUT_REG != 0) ? out_q : head;
  end

  assign bus.if_full_n   = full_n_w;
  assign bus.if_empty_n  = empty_n_w;
  assign bus.almost_full = af_w;
  assign bus.if_dout     = dout_w;
  assign bus.level       = level_w;

endmodule
